operand_feeder: RTL
===================

Name: operand_feeder

Overview:
- Producer side of the systolic array's operand request interface.
- Holds one A matrix (N x K) and one B matrix (K x M), loaded through a simple write port.
- Once started, answers the array's per-row A enable and per-column B enable requests with the next operand for that lane.
- Signals completion back to the array's controller once every operand has been consumed.

Parameters:
- DATA_WIDTH, 32, operand width in bits
- N, 3, array rows (number of A lanes)
- M, 3, array columns (number of B lanes)
- K, 3, inner dimension (operands per lane)
- ADDR_W, 4, write address width; must satisfy 2^ADDR_W >= max(N*K, K*M)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous reset, active-high
- wr_en  in  1  write strobe for operand storage
- wr_sel  in  1  0 selects the A buffer, 1 selects the B buffer
- wr_addr  in  ADDR_W  A address is i*K+k (row-major); B address is k*M+j
- wr_data  in  DATA_WIDTH  operand value to write
- start  in  1  single-cycle pulse that begins streaming
- A_in_en  in  N  per-row request from the array; bit i high means row i consumes an operand this cycle
- B_in_en  in  M  per-column request from the array; bit j high means column j consumes an operand this cycle
- A_out  out  N*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- B_out  out  M*DATA_WIDTH  lane j occupies bits [j*DATA_WIDTH +: DATA_WIDTH]
- ready  out  1  high in IDLE; storage is writable
- finished  out  1  all N*K A operands and all K*M B operands have been consumed
- overrun  out  1  sticky flag: a request arrived on an exhausted lane or outside STREAM

Behaviour:
- Reset (asynchronous) values:
  - state=IDLE, ready=1, finished=0, overrun=0
  - all lane indices = 0; A_out = 0, B_out = 0
  - buffer contents are not reset.
- State machine:
  - IDLE -> STREAM on start.
  - STREAM -> DONE on the cycle in which the last outstanding operand is consumed.
  - DONE -> STREAM on start.
  - No other transitions.
- Writes:
  - Committed on the clock edge when wr_en=1 in IDLE.
  - Ignored in STREAM and DONE.
  - Addresses beyond N*K-1 (A) or K*M-1 (B) are ignored.
  - wr_en and start in the same IDLE cycle: the write commits, then streaming begins on the next cycle.
- Lane indices:
  - Each A row i has an index a_idx[i] in 0..K; each B column j has an index b_idx[j] in 0..K.
  - start resets all indices to 0 on the transition edge.
- Output data (combinational, zero latency):
  - A_out lane i = A[i][a_idx[i]] when in STREAM and a_idx[i] < K; otherwise 0.
  - B_out lane j = B[b_idx[j]][j] under the same rule.
  - This matches the array's same-cycle muxing on its enables.
- Consume:
  - On the rising edge with state=STREAM, A_in_en[i]=1 and a_idx[i] < K: a_idx[i] increments. B lanes behave the same way.
  - Lanes are independent; any subset may request in the same cycle, which supports the skewed start.
- Overrun:
  - Set when any enable bit is high while its lane index equals K, or when any enable is high outside STREAM.
  - Index unchanged and the output stays 0.
  - Cleared only by rst.
- finished:
  - Registered; rises on the edge where the final consume brings every index to K (same edge as STREAM->DONE).
  - Held high throughout DONE.
  - Falls on the edge that leaves DONE on start.
- start while in STREAM: ignored; indices are not reset.
- ready = (state == IDLE). DONE is not writable; the same matrices are re-streamed on the next start.
- Reset mid-stream: returns immediately to IDLE with all indices 0; buffers keep their data.

Test Plan:
- Load A = {1..9} at A addresses 0..8 and B = {10..18} at B addresses 0..8, pulse start, hold A_in_en=3'b111 and B_in_en=3'b111 for 3 cycles.
  - A_out lane0 reads 1,2,3; lane2 reads 7,8,9; B_out lane1 reads 11,14,17.
  - finished=1 on the 3rd edge; state DONE.
- Skewed enables (row i and column j enabled starting at cycle i/j, 3 cycles each).
  - finished rises exactly on the edge after cycle 4 (the last consume of row 2 and column 2).
  - All outputs 0 after exhaustion; overrun=0.
- After finished, hold A_in_en[0]=1 for one cycle.
  - overrun=1 and stays 1; A_out lane0=0; finished stays 1.
- Write to A address 4 while in STREAM with data 0xDEAD.
  - After reset and start, A_out lane1 on its second operand still shows the original 5.
- Assert rst mid-stream after 1 consume.
  - finished=0, ready=1, outputs 0 immediately.
  - A new start re-streams from index 0 (lane0 reads 1 first).
- From DONE, pulse start with no new writes.
  - finished falls on the next edge; streaming repeats 1,2,3 on lane0.
  - start pulsed again mid-stream is ignored (lane0 continues 2,3 rather than restarting).

Source files
------------

// File: rtl/operand_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : operand_feeder
//  Purpose  : Operand source for the systolic array. Holds one A matrix
//             (N x K) and one B matrix (K x M). While streaming, it serves
//             each A row and each B column with that lane's next operand on
//             request, and flags completion once every operand is consumed.
//  Revision : 1.0  initial release
// ============================================================================
module operand_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 3,
    parameter int M          = 3,
    parameter int K          = 3,
    parameter int ADDR_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    start,
    input  logic [N-1:0]            A_in_en,
    input  logic [M-1:0]            B_in_en,
    output logic [N*DATA_WIDTH-1:0] A_out,
    output logic [M*DATA_WIDTH-1:0] B_out,
    output logic                    ready,
    output logic                    finished,
    output logic                    overrun
);

    localparam int IDX_W = $clog2(K + 1);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W:0] A_SIZE = (ADDR_W + 1)'(N * K);
    localparam logic [ADDR_W:0] B_SIZE = (ADDR_W + 1)'(K * M);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  finished_q, finished_d;
    logic                  overrun_q, overrun_d;

    logic [DATA_WIDTH-1:0] a_mem_q [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] b_mem_q [0:DEPTH-1];

    // Lane index counts operands consumed; the value K marks an exhausted lane.
    logic [IDX_W-1:0]      a_idx_q [0:N-1];
    logic [IDX_W-1:0]      a_idx_d [0:N-1];
    logic [IDX_W-1:0]      b_idx_q [0:M-1];
    logic [IDX_W-1:0]      b_idx_d [0:M-1];

    logic                  w_streaming;
    logic                  w_start_ok;
    logic                  w_wr_ok;
    logic                  w_all_fin;
    logic [N-1:0]          w_a_live, w_a_adv, w_a_ovr, w_a_fin;
    logic [M-1:0]          w_b_live, w_b_adv, w_b_ovr, w_b_fin;

    assign w_streaming = (state_q == S_STREAM);
    assign w_start_ok  = start & ~w_streaming;
    assign w_wr_ok     = wr_en & (state_q == S_IDLE);
    assign w_all_fin   = (&w_a_fin) & (&w_b_fin);

    // Per-row A lane: operand mux, consume decision, exhaustion tracking.
    // The exhausted index is steered to 0 so the read never leaves the row.
    for (genvar gi = 0; gi < N; gi++) begin : g_a_lane
        logic [IDX_W-1:0]  w_sel;
        logic [ADDR_W-1:0] w_addr;

        assign w_a_live[gi] = (a_idx_q[gi] != IDX_W'(K));
        assign w_sel        = w_a_live[gi] ? a_idx_q[gi] : '0;
        assign w_addr       = ADDR_W'(gi * K) + ADDR_W'(w_sel);
        assign A_out[gi*DATA_WIDTH +: DATA_WIDTH] =
            (w_streaming && w_a_live[gi]) ? a_mem_q[w_addr] : '0;
        assign w_a_adv[gi]  = w_streaming & A_in_en[gi] & w_a_live[gi];
        assign w_a_ovr[gi]  = A_in_en[gi] & ~w_a_live[gi];
        assign w_a_fin[gi]  = ~w_a_live[gi] |
                              (w_a_adv[gi] & (a_idx_q[gi] == IDX_W'(K - 1)));
    end

    // Per-column B lane: B is stored row-major by k, so column j strides by M.
    for (genvar gj = 0; gj < M; gj++) begin : g_b_lane
        logic [IDX_W-1:0]  w_sel;
        logic [ADDR_W-1:0] w_addr;

        assign w_b_live[gj] = (b_idx_q[gj] != IDX_W'(K));
        assign w_sel        = w_b_live[gj] ? b_idx_q[gj] : '0;
        assign w_addr       = ADDR_W'(w_sel) * ADDR_W'(M) + ADDR_W'(gj);
        assign B_out[gj*DATA_WIDTH +: DATA_WIDTH] =
            (w_streaming && w_b_live[gj]) ? b_mem_q[w_addr] : '0;
        assign w_b_adv[gj]  = w_streaming & B_in_en[gj] & w_b_live[gj];
        assign w_b_ovr[gj]  = B_in_en[gj] & ~w_b_live[gj];
        assign w_b_fin[gj]  = ~w_b_live[gj] |
                              (w_b_adv[gj] & (b_idx_q[gj] == IDX_W'(K - 1)));
    end

    // Next-state: start (from IDLE or DONE) rewinds all lanes; streaming
    // advances requested lanes and leaves for DONE on the final consume.
    always_comb begin
        state_d    = state_q;
        finished_d = finished_q;
        for (int i = 0; i < N; i++) a_idx_d[i] = a_idx_q[i];
        for (int j = 0; j < M; j++) b_idx_d[j] = b_idx_q[j];

        if (w_start_ok) begin
            state_d    = S_STREAM;
            finished_d = 1'b0;
            for (int i = 0; i < N; i++) a_idx_d[i] = '0;
            for (int j = 0; j < M; j++) b_idx_d[j] = '0;
        end else if (w_streaming) begin
            for (int i = 0; i < N; i++) a_idx_d[i] = a_idx_q[i] + IDX_W'(w_a_adv[i]);
            for (int j = 0; j < M; j++) b_idx_d[j] = b_idx_q[j] + IDX_W'(w_b_adv[j]);
            if (w_all_fin) begin
                state_d    = S_DONE;
                finished_d = 1'b1;
            end
        end
    end

    // Any request on an exhausted lane, or any request outside STREAM, is sticky.
    assign overrun_d = overrun_q |
                       (w_streaming ? ((|w_a_ovr) | (|w_b_ovr))
                                    : ((|A_in_en) | (|B_in_en)));

    // Control state, lane indices and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            finished_q <= 1'b0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < N; i++) a_idx_q[i] <= '0;
            for (int j = 0; j < M; j++) b_idx_q[j] <= '0;
        end else begin
            state_q    <= state_d;
            finished_q <= finished_d;
            overrun_q  <= overrun_d;
            for (int i = 0; i < N; i++) a_idx_q[i] <= a_idx_d[i];
            for (int j = 0; j < M; j++) b_idx_q[j] <= b_idx_d[j];
        end
    end

    // Operand storage: writable only in IDLE, out-of-range addresses dropped,
    // contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok && !wr_sel && ({1'b0, wr_addr} < A_SIZE)) begin
            a_mem_q[wr_addr] <= wr_data;
        end
        if (w_wr_ok && wr_sel && ({1'b0, wr_addr} < B_SIZE)) begin
            b_mem_q[wr_addr] <= wr_data;
        end
    end

    assign ready    = (state_q == S_IDLE);
    assign finished = finished_q;
    assign overrun  = overrun_q;

endmodule
`default_nettype wire
